serial_pair_loader: RTL and testbench
=====================================

# serial_pair_loader

Serial-to-parallel front end for the 8-bit equality comparator. Accepts one bit of operand A and one bit of operand B per accepted beat, LSB first, and assembles them into two parallel words. The completed pair is held in an output register with a valid/ready handshake, so the comparator sees stable operands for as long as the consumer needs them. A two-deep arrangement (shift register plus output register) lets the next pair fill while the previous one is still being consumed.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clock  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a_bit/b_bit carry a valid beat.
- in_ready  out  1  loader can accept a beat this cycle.
- a_bit  in  1  next bit of operand A, LSB first.
- b_bit  in  1  next bit of operand B, LSB first.
- clear  in  1  synchronous discard of the partially assembled pair; the output register is not affected.
- a  out  WIDTH  assembled operand A, drives comparator input a.
- b  out  WIDTH  assembled operand B, drives comparator input b.
- out_valid  out  1  a/b hold a complete pair.
- out_ready  in  1  consumer takes the pair this cycle.
- bit_count  out  log2(WIDTH)  number of bits already collected in the current partial pair.

## Operation
- Beat accepted when in_valid && in_ready; shift registers sa/sb shift right, new bit enters at MSB side, so after WIDTH beats bit 0 is the first bit received.
- bit_count increments per accepted beat, 0..WIDTH-1, then wraps to 0 on the completing beat.
- Completing beat (accepted while bit_count == WIDTH-1) loads a <= {a_bit, sa[WIDTH-1:1]}, b likewise, sets out_valid, and clears bit_count.
- Output handshake: pair consumed when out_valid && out_ready; out_valid drops next cycle unless a completing beat loads a new pair in the same cycle, in which case out_valid stays 1 and a/b update.
- in_ready = !(bit_count == WIDTH-1 && out_valid && !out_ready); the loader only stalls on the completing beat while the output register is still occupied. Non-completing beats are always accepted.
- a/b are stable whenever out_valid is 1 and out_ready is 0. Outside a load they keep their last value, and they are never cleared except by reset.
- clear: bit_count <= 0 and shift registers <= 0; any beat presented in the same cycle is discarded (clear wins). out_valid, a and b are unchanged.
- FSM view: FILL (out_valid=0), FULL_FILL (out_valid=1, filling), STALL (out_valid=1, bit_count=WIDTH-1, !out_ready → in_ready=0). Transitions follow the rules above.

## Timing
- Reset (rst_n low, async): a=0, b=0, out_valid=0, bit_count=0, shift registers 0, in_ready=1.
- Latency: the pair appears on a/b with out_valid=1 on the first edge after the completing beat is accepted, i.e. the cycle after the WIDTH-th beat.
- Throughput: one pair per WIDTH cycles with in_valid and out_ready held high, with no bubbles.
- Reset asserted mid-word discards the partial pair and any held output. No beat is accepted while rst_n is low.
- in_ready is combinational from bit_count, out_valid and out_ready. No combinational path exists from in_valid to in_ready.

## Test plan
- Reset then 8 beats A=0xA5, B=0xA5 (LSB first), out_ready=1 → cycle after beat 8: a=0xA5, b=0xA5, out_valid=1 for one cycle; comparator equal=1.
- Back-to-back pairs 0x3C/0x3D then 0xFF/0xFF with continuous in_valid and out_ready → out_valid pulses every 8 cycles, no stall, and equal goes 0 then 1.
- out_ready=0 after first pair 0x12/0x34; feed the next 8 beats → beats 1–7 accepted, in_ready=0 on beat 8, a/b hold 0x12/0x34. Raise out_ready → same cycle beat 8 accepted, next cycle a/b become the new pair and out_valid stays 1.
- clear after 5 beats, then 8 fresh beats 0x81/0x81 → output is 0x81/0x81, with no residue of the discarded bits. clear in the same cycle as a beat → bit_count=0.
- rst_n pulsed low asynchronously (between edges) at bit_count=4 with out_valid=1 → immediate a=b=0, out_valid=0, bit_count=0, in_ready=1.
- Random 1000-pair soak with random in_valid/out_ready: a scoreboard checks every consumed pair against the serial stream, verifies no loss or duplication, and checks a/b stable while out_valid && !out_ready.

Source files
------------

// File: rtl/serial_pair_loader.sv
// Serial-to-parallel loader: collects LSB-first A/B bit pairs into WIDTH-bit words
// and presents each completed pair through a valid/ready output register.
module serial_pair_loader #(
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     a_bit,
    input  logic                     b_bit,
    input  logic                     clear,
    output logic [WIDTH-1:0]         a,
    output logic [WIDTH-1:0]         b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] bit_count
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // FILL and FULL_FILL are the registered occupancy states; STALL is the
    // combinational refinement of FULL_FILL while the completing beat must wait.
    typedef enum logic [1:0] {
        FILL      = 2'd0,
        FULL_FILL = 2'd1,
        STALL     = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    state_t phase;

    // Only WIDTH-1 bits are buffered: the WIDTH-th bit goes straight into a/b.
    logic [WIDTH-2:0] sa;
    logic [WIDTH-2:0] sb;
    logic [WIDTH-1:0] sa_next;
    logic [WIDTH-1:0] sb_next;

    logic last;
    logic accept;
    logic complete;

    assign sa_next   = {a_bit, sa};
    assign sb_next   = {b_bit, sb};
    assign out_valid = (state_q != FILL);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        phase    = state_q;
        in_ready = 1'b1;
        accept   = 1'b0;
        complete = 1'b0;
        last     = (bit_count == LAST_BIT);

        if (state_q != FILL && last && !out_ready) begin
            phase = STALL;
        end
        in_ready = (phase != STALL);

        // clear wins over a beat presented in the same cycle
        accept   = in_valid && in_ready && !clear;
        complete = accept && last;

        case (state_q)
            FILL: begin
                if (complete) state_d = FULL_FILL;
            end
            FULL_FILL: begin
                if (out_ready && !complete) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            bit_count <= '0;
            sa        <= '0;
            sb        <= '0;
            a         <= '0;
            b         <= '0;
        end else if (clear) begin
            bit_count <= '0;
            sa        <= '0;
            sb        <= '0;
        end else if (accept) begin
            if (last) begin
                bit_count <= '0;
                sa        <= '0;
                sb        <= '0;
                a         <= sa_next;
                b         <= sb_next;
            end else begin
                bit_count <= bit_count + CW'(1);
                sa        <= sa_next[WIDTH-1:1];
                sb        <= sb_next[WIDTH-1:1];
            end
        end
    end

endmodule

// File: tb/tb_serial_pair_loader.sv
// Scoreboard bench for serial_pair_loader: directed scenarios plus a random soak,
// expected pairs queued at issue time and checked by an independent monitor.
module tb_serial_pair_loader;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    logic                     clock = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic                     a_bit;
    logic                     b_bit;
    logic                     clear;
    logic [WIDTH-1:0]         a;
    logic [WIDTH-1:0]         b;
    logic                     out_valid;
    logic                     out_ready;
    logic [$clog2(WIDTH)-1:0] bit_count;

    logic dir_ready;
    logic rnd_ready;
    logic soak_en;

    pair_t       exp_q[$];
    int unsigned pop_cyc[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cycle  = 0;
    int          stall_cnt = 0;
    int          n_push = 0;
    int          n_pop  = 0;

    assign out_ready = soak_en ? rnd_ready : dir_ready;

    always #5 clock = ~clock;

    serial_pair_loader #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .clear     (clear),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bit_count (bit_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents one beat and returns just after the edge that accepted it.
    task automatic beat(input logic ab, input logic bb);
        logic acc;
        in_valid = 1'b1;
        a_bit    = ab;
        b_bit    = bb;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            acc = in_ready;
            step();
            if (acc) return;
        end
        check("beat_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_pair(input logic [WIDTH-1:0] pa, input logic [WIDTH-1:0] pb,
                             input logic push, input logic gaps);
        if (push) begin
            exp_q.push_back('{a: pa, b: pb});
            n_push++;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) step();
            end
            beat(pa[i], pb[i]);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        clear     = 1'b0;
        dir_ready = 1'b1;
        rnd_ready = 1'b0;
        soak_en   = 1'b0;

        fork
            forever begin
                @(posedge clock);
                cycle++;
            end
            forever begin
                @(posedge clock);
                #1;
                rnd_ready = 1'($urandom_range(0, 1));
            end
            // Monitor: every presented pair must match the head of the queue;
            // the head is only retired on the cycle the consumer takes it.
            forever begin
                @(negedge clock);
                if (rst_n) begin
                    if (in_valid && !in_ready) stall_cnt++;
                    if (out_valid) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_pair: got a=%0h b=%0h, none expected", a, b);
                        end else begin
                            check("pair_a", a, exp_q[0].a);
                            check("pair_b", b, exp_q[0].b);
                            if (out_ready) begin
                                check("equal", a == b, exp_q[0].a == exp_q[0].b);
                                void'(exp_q.pop_front());
                                n_pop++;
                                pop_cyc.push_back(cycle);
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) step();
        @(negedge clock);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_bit_count", bit_count, 0);
        check("rst_in_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
        step();

        // Single pair, one-cycle valid pulse
        send_pair(8'hA5, 8'hA5, 1'b1, 1'b0);
        in_valid = 1'b0;
        @(negedge clock);
        check("single_out_valid", out_valid, 1);
        step();
        @(negedge clock);
        check("single_valid_drop", out_valid, 0);
        step();

        // Back-to-back pairs at full throughput
        pop_cyc.delete();
        stall_cnt = 0;
        send_pair(8'h3C, 8'h3D, 1'b1, 1'b0);
        send_pair(8'hFF, 8'hFF, 1'b1, 1'b0);
        in_valid = 1'b0;
        repeat (2) step();
        check("b2b_pops", pop_cyc.size(), 2);
        if (pop_cyc.size() == 2) check("b2b_spacing", pop_cyc[1] - pop_cyc[0], WIDTH);
        check("b2b_no_stall", stall_cnt, 0);

        // Output held while the next pair completes
        dir_ready = 1'b0;
        send_pair(8'h12, 8'h34, 1'b1, 1'b0);
        exp_q.push_back('{a: 8'h56, b: 8'h78});
        n_push++;
        for (int i = 0; i < WIDTH - 1; i++) begin
            beat(1'(8'h56 >> i), 1'(8'h78 >> i));
        end
        in_valid = 1'b1;
        a_bit    = 1'b0;
        b_bit    = 1'b0;
        @(negedge clock);
        check("stall_in_ready", in_ready, 0);
        check("stall_bit_count", bit_count, WIDTH - 1);
        step();
        @(negedge clock);
        check("stall_hold_in_ready", in_ready, 0);
        check("stall_hold_a", a, 8'h12);
        check("stall_hold_b", b, 8'h34);
        step();
        dir_ready = 1'b1;
        @(negedge clock);
        check("release_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clock);
        check("reload_out_valid", out_valid, 1);
        check("reload_a", a, 8'h56);
        check("reload_b", b, 8'h78);
        step();

        // clear discards partial bits, held output untouched
        dir_ready = 1'b0;
        send_pair(8'h66, 8'h99, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0);
        in_valid = 1'b1;
        clear    = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        check("clear_bit_count", bit_count, 0);
        check("clear_out_valid", out_valid, 1);
        check("clear_a_held", a, 8'h66);
        step();
        dir_ready = 1'b1;
        send_pair(8'h81, 8'h81, 1'b1, 1'b0);
        in_valid = 1'b0;
        repeat (3) step();

        // Asynchronous reset mid-word with a held pair
        dir_ready = 1'b0;
        send_pair(8'h5A, 8'hC3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) beat(1'b1, 1'b0);
        in_valid = 1'b0;
        @(negedge clock);
        check("pre_rst_bit_count", bit_count, 4);
        check("pre_rst_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_a", a, 0);
        check("arst_b", b, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_bit_count", bit_count, 0);
        check("arst_in_ready", in_ready, 1);
        exp_q.delete();
        n_push--;
        in_valid = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clock);
        check("post_rst_bit_count", bit_count, 0);
        check("post_rst_out_valid", out_valid, 0);
        step();
        dir_ready = 1'b1;

        // Random soak
        soak_en = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            send_pair(WIDTH'($urandom), WIDTH'($urandom), 1'b1, 1'b1);
        end
        in_valid = 1'b0;
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) step();
        soak_en = 1'b0;
        check("soak_drained", exp_q.size(), 0);
        check("soak_no_loss", n_pop, n_push);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
